// File: rtl/reg_dump_pkg.sv
// ---------------------------------------------------------------------------
// reg_dump_pkg : shared state encoding and framing constants for the dumper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package reg_dump_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_e;

  localparam int DATA_BITS      = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int REG_IDX_W      = 5;

  // Byte 0 is the most significant byte of the word.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_dump_uart_tx.sv
// ---------------------------------------------------------------------------
// reg_dump_uart_tx : walks the register file and streams each word, MSB first, as UART 8N1
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_dump_uart_tx
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int NREGS        = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic [REG_IDX_W-1:0] reg_sel,
  input  logic [31:0]          reg_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int                   BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]    BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]           BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [1:0]           BYTE_LAST = 2'(BYTES_PER_WORD - 1);
  localparam logic [REG_IDX_W-1:0] REG_LAST  = REG_IDX_W'(NREGS - 1);

  state_e                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [1:0]             byte_q, byte_d;
  logic [31:0]            word_q, word_d;
  logic [REG_IDX_W-1:0]   sel_q, sel_d;
  logic                   busy_q, busy_d;
  logic                   fin_q, fin_d;
  logic                   done_q;
  logic                   tx_q, tx_d;
  logic                   baud_end;
  logic [7:0]             cur_byte;

  assign baud_end = (baud_q == BAUD_LAST);
  assign cur_byte = word_byte(word_q, byte_q);

  // The line level and the done strobe are registered one cycle behind the
  // FSM, so start requests are refused until that trailing pulse has gone.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    fin_d   = 1'b0;
    tx_d    = 1'b1;
    if (fin_q) busy_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !fin_q && !done_q) begin
          sel_d   = '0;
          busy_d  = 1'b1;
          state_d = SEL;
        end
      end
      SEL: begin
        word_d  = reg_data;
        byte_d  = 2'd0;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        tx_d = cur_byte[bit_q];
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q != BYTE_LAST) begin
            byte_d  = byte_q + 2'd1;
            state_d = START;
          end else if (sel_q != REG_LAST) begin
            sel_d   = sel_q + REG_IDX_W'(1);
            state_d = SEL;
          end else begin
            sel_d   = '0;
            fin_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      word_q  <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      done_q  <= fin_q;
      tx_q    <= tx_d;
    end
  end

  assign reg_sel = sel_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_uart_tx : directed/randomised checks of the register dumper against a UART-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reg_dump_uart_tx;

  localparam int C       = 4;
  localparam int REG_CYC = 1 + 40 * C;
  localparam int BIG_N   = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start1 = 1'b0;
  logic        start32 = 1'b0;
  logic [4:0]  sel1, sel32;
  logic [31:0] data1 = 32'h0;
  logic [31:0] data32;
  logic        tx1, tx32, busy1, busy32, done1, done32;

  int n_checks = 0;
  int n_err    = 0;

  bit         tx_s[$];
  bit         done_s[$];
  bit         busy_s[$];
  logic [4:0] sel_s[$];

  always #5 clk = ~clk;

  // Register-file model for the 32-register instance.
  always_comb data32 = {27'h0, sel32} ^ 32'hA5A5A5A5;

  reg_dump_uart_tx #(.CLKS_PER_BIT(C), .NREGS(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .reg_sel(sel1),
    .reg_data(data1), .tx(tx1), .busy(busy1), .done(done1)
  );

  reg_dump_uart_tx #(.CLKS_PER_BIT(C), .NREGS(BIG_N)) u_dut32 (
    .clk(clk), .rstn(rstn), .start(start32), .reg_sel(sel32),
    .reg_data(data32), .tx(tx32), .busy(busy32), .done(done32)
  );

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed 'h%0h, expected 'h%0h", tag, idx, obs, exp);
    end
  endtask

  // mode 0: fixed 0x12345678, mode 1: 0xDEADBEEF, mode 2: index ^ A5A5A5A5
  function automatic logic [31:0] exp_word(input int mode, input int r);
    logic [4:0] r5;
    r5 = 5'(r);
    if (mode == 0) return 32'h12345678;
    if (mode == 1) return 32'hDEADBEEF;
    return {27'h0, r5} ^ 32'hA5A5A5A5;
  endfunction

  // Sample index k holds the outputs just after the k-th edge following the start-sampling edge.
  task automatic run_dump(input bit big, input int ncyc, input bit repulse, input bit toggle);
    int done_idx;
    done_idx = BIG_N * REG_CYC + 1;
    @(negedge clk);
    if (big) start32 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    start1  = 1'b0;
    tx_s.delete(); done_s.delete(); busy_s.delete(); sel_s.delete();
    for (int k = 0; k < ncyc; k++) begin
      tx_s.push_back(big ? tx32 : tx1);
      done_s.push_back(big ? done32 : done1);
      busy_s.push_back(big ? busy32 : busy1);
      sel_s.push_back(big ? sel32 : sel1);
      if (toggle && k >= 1) data1 = ~data1;
      if (repulse && (k == 10 || k == 50 || k == 300 || k == done_idx)) start32 = 1'b1;
      else start32 = 1'b0;
      @(posedge clk); #1;
    end
    start32 = 1'b0;
  endtask

  task automatic check_dump(input int nregs, input int mode);
    int         done_at;
    int         nb;
    int         k;
    int         r;
    int         j;
    logic [7:0] b;
    logic [31:0] w;
    done_at = nregs * REG_CYC + 1;
    for (int i = 0; i < tx_s.size(); i++) begin
      check("done", i, 32'(done_s[i]), 32'(i == done_at));
      check("busy", i, 32'(busy_s[i]), 32'(i < done_at));
      check("reg_sel", i, 32'(sel_s[i]), (i < nregs * REG_CYC) ? 32'(i / REG_CYC) : 32'h0);
    end
    nb = 0;
    k  = 0;
    while (k < tx_s.size()) begin
      if (tx_s[k] == 1'b0) begin
        r = nb / 4;
        j = nb % 4;
        check("frame_pos", nb, 32'(k), 32'(2 + r * REG_CYC + j * 10 * C));
        if (k + 10 * C > tx_s.size()) begin
          check("frame_truncated", nb, 32'(k + 10 * C), 32'(tx_s.size()));
          break;
        end
        check("start_bit", nb, 32'(tx_s[k + C / 2]), 32'h0);
        for (int bi = 0; bi < 8; bi++) b[bi] = tx_s[k + C * (1 + bi) + C / 2];
        check("stop_bit", nb, 32'(tx_s[k + 9 * C + C / 2]), 32'h1);
        w = exp_word(mode, r);
        check("byte", nb, 32'(b), 32'(w[31 - 8 * j -: 8]));
        nb++;
        k += 10 * C;
      end else begin
        k++;
      end
    end
    check("nbytes", 0, 32'(nb), 32'(nregs * 4));
  endtask

  initial begin
    int big_len;
    int rnd_wait;
    big_len = BIG_N * REG_CYC + 1 + 20;

    // Reset and idle behaviour.
    repeat (3) @(negedge clk);
    check("rst_tx", 0, 32'(tx32), 32'h1);
    check("rst_busy", 0, 32'(busy32), 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check("idle_tx", i, 32'({tx1, tx32}), 32'h3);
      check("idle_busy", i, 32'({busy1, busy32}), 32'h0);
      check("idle_done", i, 32'({done1, done32}), 32'h0);
      check("idle_sel", i, 32'({sel1, sel32}), 32'h0);
    end

    // Single register.
    data1 = 32'h12345678;
    run_dump(1'b0, REG_CYC + 1 + 20, 1'b0, 1'b0);
    check_dump(1, 0);

    // Captured word is immune to later reg_data activity.
    repeat ($urandom_range(1, 7)) @(posedge clk);
    data1 = 32'hDEADBEEF;
    run_dump(1'b0, REG_CYC + 1 + 20, 1'b0, 1'b1);
    check_dump(1, 1);

    // Full dump.
    rnd_wait = $urandom_range(1, 9);
    repeat (rnd_wait) @(posedge clk);
    run_dump(1'b1, big_len, 1'b0, 1'b0);
    check_dump(BIG_N, 2);

    // Re-pulsed start mid-dump and during the done cycle must be ignored.
    run_dump(1'b1, big_len, 1'b1, 1'b0);
    check_dump(BIG_N, 2);

    // Asynchronous reset during byte 2 data bits.
    run_dump(1'b1, 100, 1'b0, 1'b0);
    check("pre_abort_busy", 0, 32'(busy32), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_tx", 0, 32'(tx32), 32'h1);
    check("abort_busy", 0, 32'(busy32), 32'h0);
    check("abort_sel", 0, 32'(sel32), 32'h0);
    check("abort_done", 0, 32'(done32), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat ($urandom_range(1, 5)) @(posedge clk);
    run_dump(1'b1, big_len, 1'b0, 1'b0);
    check_dump(BIG_N, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
